// File: rtl/pack_frame_ctrl.sv
// ============================================================================
// Module   : pack_frame_ctrl
// Brief    : Ping-pong packet memory sequencer: byte write addressing with
//            preamble skip, bit read addressing with SOP/EOP and idle gap.
//            Optional statistics counters enabled by PACK_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pack_frame_ctrl #(
    parameter int SIZE_BIT_PACK  = 1976,
    parameter int SIZE_INPUT_BIT = 8,
    parameter int SIZE_PREAMBLE  = 32,
    parameter int GAP_CYCLES     = 16,
    localparam int LENGTH_INPUT     = SIZE_BIT_PACK / SIZE_INPUT_BIT,
    localparam int LENGTH_OUTPUT    = SIZE_BIT_PACK,
    localparam int SIZE_ADDR_INPUT  = $clog2(LENGTH_INPUT),
    localparam int SIZE_ADDR_OUTPUT = $clog2(LENGTH_OUTPUT)
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_valid_input,
    output logic                        o_ready,
    output logic                        o_wr_en,
    output logic [SIZE_ADDR_INPUT-1:0]  o_wr_addr,
    output logic                        o_wr_bank,
    input  logic                        i_ready_output,
    output logic                        o_valid,
    output logic [SIZE_ADDR_OUTPUT-1:0] o_rd_addr,
    output logic                        o_rd_bank,
`ifdef PACK_CTRL_STATS_EN
    output logic [15:0]                 o_pack_cnt,
    output logic [15:0]                 o_stall_cnt,
`endif
    output logic                        o_sop,
    output logic                        o_eop
);

    localparam int ADDR_FIRST_WRITE = SIZE_PREAMBLE / SIZE_INPUT_BIT;
    localparam int GAP_W            = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [SIZE_ADDR_INPUT-1:0]  c_wr_first = SIZE_ADDR_INPUT'(ADDR_FIRST_WRITE);
    localparam logic [SIZE_ADDR_INPUT-1:0]  c_wr_last  = SIZE_ADDR_INPUT'(LENGTH_INPUT - 1);
    localparam logic [SIZE_ADDR_OUTPUT-1:0] c_rd_last  = SIZE_ADDR_OUTPUT'(LENGTH_OUTPUT - 1);
    localparam logic [GAP_W-1:0]            c_gap_last =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [SIZE_ADDR_INPUT-1:0]  r_wr_addr;
    logic                        r_wr_bank;
    logic [SIZE_ADDR_OUTPUT-1:0] r_rd_addr;
    logic [SIZE_ADDR_OUTPUT-1:0] w_rd_addr_next;
    logic                        r_rd_bank;
    logic [1:0]                  r_full;
    logic [1:0]                  w_full_next;
    logic [GAP_W-1:0]            r_gap_cnt;
    logic [GAP_W-1:0]            w_gap_next;
    logic                        w_ready;
    logic                        w_wr_en;
    logic                        w_wr_done;
    logic                        w_rd_done;
    logic                        w_valid;

    // Write side: a bank stays locked until the reader has drained it.
    assign w_ready   = ~r_full[r_wr_bank];
    assign w_wr_en   = i_valid_input & w_ready;
    assign w_wr_done = w_wr_en & (r_wr_addr == c_wr_last);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_addr <= c_wr_first;
            r_wr_bank <= 1'b0;
        end else if (w_wr_en) begin
            if (w_wr_done) begin
                r_wr_addr <= c_wr_first;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    // Set and clear never address the same bank, so both apply together.
    always_comb begin
        w_full_next = r_full;
        if (w_wr_done) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_rd_addr_next = r_rd_addr;
        w_gap_next     = r_gap_cnt;
        w_rd_done      = 1'b0;
        w_valid        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_next   = ST_SEND;
                    w_rd_addr_next = '0;
                end
            end
            ST_SEND: begin
                w_valid = 1'b1;
                if (i_ready_output) begin
                    if (r_rd_addr == c_rd_last) begin
                        w_rd_done      = 1'b1;
                        w_rd_addr_next = '0;
                        w_gap_next     = '0;
                        w_state_next   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        w_rd_addr_next = r_rd_addr + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_next = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_addr <= '0;
            r_rd_bank <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_rd_addr <= w_rd_addr_next;
            r_gap_cnt <= w_gap_next;
            if (w_rd_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

`ifdef PACK_CTRL_STATS_EN
    logic [15:0] r_pack_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pack_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_rd_done && (r_pack_cnt != 16'hFFFF)) begin
                r_pack_cnt <= r_pack_cnt + 1'b1;
            end
            if (i_valid_input && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_pack_cnt  = r_pack_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_ready   = w_ready;
    assign o_wr_en   = w_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_bank = r_wr_bank;
    assign o_valid   = w_valid;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_bank = r_rd_bank;
    assign o_sop     = w_valid & (r_rd_addr == '0);
    assign o_eop     = w_valid & (r_rd_addr == c_rd_last);

endmodule

`default_nettype wire

// File: tb/tb_pack_frame_ctrl.sv
// ============================================================================
// Module   : tb_pack_frame_ctrl
// Brief    : Self-checking bench for pack_frame_ctrl (64-bit packets, 16-bit
//            preamble, gap of 2) with vector table, corner sequences and a
//            packet-level reference model under random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pack_frame_ctrl;

    localparam int P_BITS  = 64;
    localparam int P_IN    = 8;
    localparam int P_PRE   = 16;
    localparam int P_GAP   = 2;
    localparam int N_WORDS = P_BITS / P_IN;
    localparam int FIRST   = P_PRE / P_IN;
    localparam int PAYLOAD = N_WORDS - FIRST;

    logic       i_clk;
    logic       i_reset_n;
    logic       i_valid_input;
    logic       o_ready;
    logic       o_wr_en;
    logic [2:0] o_wr_addr;
    logic       o_wr_bank;
    logic       i_ready_output;
    logic       o_valid;
    logic [5:0] o_rd_addr;
    logic       o_rd_bank;
    logic       o_sop;
    logic       o_eop;
`ifdef PACK_CTRL_STATS_EN
    logic [15:0] o_pack_cnt;
    logic [15:0] o_stall_cnt;
`endif

    pack_frame_ctrl #(
        .SIZE_BIT_PACK (P_BITS),
        .SIZE_INPUT_BIT(P_IN),
        .SIZE_PREAMBLE (P_PRE),
        .GAP_CYCLES    (P_GAP)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_valid_input (i_valid_input),
        .o_ready       (o_ready),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_wr_bank     (o_wr_bank),
        .i_ready_output(i_ready_output),
        .o_valid       (o_valid),
        .o_rd_addr     (o_rd_addr),
        .o_rd_bank     (o_rd_bank),
`ifdef PACK_CTRL_STATS_EN
        .o_pack_cnt    (o_pack_cnt),
        .o_stall_cnt   (o_stall_cnt),
`endif
        .o_sop         (o_sop),
        .o_eop         (o_eop)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Packet-level model: words collected per packet, bits sent per packet,
    // idle cycles still to wait before the reader may look for a full bank.
    int m_wcount, m_wbank, m_rbank, m_bit, m_wait, m_pack, m_stall;
    bit m_full[2];
    bit m_sending;

    task automatic m_reset();
        m_wcount = 0; m_wbank = 0; m_rbank = 0; m_bit = 0; m_wait = 0;
        m_full[0] = 0; m_full[1] = 0; m_sending = 0;
        m_pack = 0; m_stall = 0;
    endtask

    task automatic m_check();
        bit rdy;
        rdy = !m_full[m_wbank];
        chk("ready",   o_ready,   rdy);
        chk("wr_en",   o_wr_en,   (i_valid_input && rdy) ? 1 : 0);
        chk("wr_addr", o_wr_addr, FIRST + m_wcount);
        chk("wr_bank", o_wr_bank, m_wbank);
        chk("valid",   o_valid,   m_sending);
        chk("rd_addr", o_rd_addr, m_bit);
        chk("rd_bank", o_rd_bank, m_rbank);
        chk("sop",     o_sop,     (m_sending && m_bit == 0) ? 1 : 0);
        chk("eop",     o_eop,     (m_sending && m_bit == P_BITS - 1) ? 1 : 0);
    endtask

    task automatic m_advance(input bit vin, input bit rout);
        bit old_full[2];
        bit wr;
        old_full = m_full;
        wr = vin && !old_full[m_wbank];
        if (vin && old_full[m_wbank] && m_stall < 65535) m_stall++;
        if (m_sending) begin
            if (rout) begin
                if (m_bit == P_BITS - 1) begin
                    if (m_pack < 65535) m_pack++;
                    m_full[m_rbank] = 0;
                    m_rbank ^= 1;
                    m_bit = 0;
                    m_sending = 0;
                    m_wait = P_GAP;
                end else begin
                    m_bit++;
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (old_full[m_rbank]) begin
            m_sending = 1;
        end
        if (wr) begin
            if (m_wcount == PAYLOAD - 1) begin
                m_full[m_wbank] = 1;
                m_wbank ^= 1;
                m_wcount = 0;
            end else begin
                m_wcount++;
            end
        end
    endtask

    // Entry/exit point of every cycle is 1 time unit after the rising edge.
    task automatic apply(input bit vin, input bit rout);
        i_valid_input  = vin;
        i_ready_output = rout;
        #1;
        m_check();
    endtask

    task automatic tick();
        @(posedge i_clk);
        m_advance(i_valid_input, i_ready_output);
        #1;
    endtask

    task automatic cycle(input bit vin, input bit rout);
        apply(vin, rout);
        tick();
    endtask

    task automatic do_reset();
        i_reset_n      = 1'b0;
        i_valid_input  = 1'b0;
        i_ready_output = 1'b0;
        #1;
        m_reset();
        chk("rst_valid",   o_valid,   0);
        chk("rst_ready",   o_ready,   1);
        chk("rst_wr_addr", o_wr_addr, FIRST);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    typedef struct {
        bit vin;
        bit rout;
        bit e_ready;
        bit e_wr_en;
        int e_wr_addr;
        bit e_wr_bank;
        bit e_valid;
        int e_rd_addr;
        bit e_sop;
        bit e_eop;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, gap_seen, wen_cnt, k, thresh;
        bit seen, found, done;

        tbl[0] = '{1, 1, 1, 1, 2, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 1, 3, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 1, 1, 1, 4, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 1, 1, 1, 5, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 1, 1, 1, 6, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 1, 1, 1, 7, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 1, 1, 0, 2, 1, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 1, 0, 2, 1, 1, 0, 1, 0};
        tbl[8] = '{0, 1, 1, 0, 2, 1, 1, 0, 1, 0};
        tbl[9] = '{0, 1, 1, 0, 2, 1, 1, 1, 0, 0};

        i_reset_n      = 1'b0;
        i_valid_input  = 1'b0;
        i_ready_output = 1'b0;
        m_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_valid",   o_valid,   0);
        chk("reset_sop",     o_sop,     0);
        chk("reset_eop",     o_eop,     0);
        chk("reset_ready",   o_ready,   1);
        chk("reset_wr_addr", o_wr_addr, FIRST);
        chk("reset_wr_bank", o_wr_bank, 0);
        chk("reset_rd_addr", o_rd_addr, 0);
        chk("reset_rd_bank", o_rd_bank, 0);
        i_reset_n = 1'b1;

        // First packet written back-to-back, then SOP and first handshakes.
        foreach (tbl[i]) begin
            apply(tbl[i].vin, tbl[i].rout);
            chk($sformatf("tbl%0d_ready", i),   o_ready,   tbl[i].e_ready);
            chk($sformatf("tbl%0d_wr_en", i),   o_wr_en,   tbl[i].e_wr_en);
            chk($sformatf("tbl%0d_wr_addr", i), o_wr_addr, tbl[i].e_wr_addr);
            chk($sformatf("tbl%0d_wr_bank", i), o_wr_bank, tbl[i].e_wr_bank);
            chk($sformatf("tbl%0d_valid", i),   o_valid,   tbl[i].e_valid);
            chk($sformatf("tbl%0d_rd_addr", i), o_rd_addr, tbl[i].e_rd_addr);
            chk($sformatf("tbl%0d_sop", i),     o_sop,     tbl[i].e_sop);
            chk($sformatf("tbl%0d_eop", i),     o_eop,     tbl[i].e_eop);
            tick();
        end

        // Downstream always ready: 64 consecutive bits, then an idle gap.
        do_reset();
        repeat (PAYLOAD) cycle(1'b1, 1'b1);
        n = 0; gap_seen = 0; seen = 0;
        for (int c = 0; c < 200; c++) begin
            apply(1'b0, 1'b1);
            if (o_valid) begin
                seen = 1;
                chk("tied_rd_addr", o_rd_addr, n);
                chk("tied_sop", o_sop, (n == 0) ? 1 : 0);
                chk("tied_eop", o_eop, (n == P_BITS - 1) ? 1 : 0);
                n++;
            end else if (seen) begin
                gap_seen++;
            end
            tick();
            if (gap_seen == P_GAP) break;
        end
        chk("tied_bit_count", n, P_BITS);
        chk("tied_gap_count", gap_seen, P_GAP);

        // Both banks full: writer stalls after 12 words until the EOP.
        do_reset();
        wen_cnt = 0;
        for (int c = 0; c < 2 * PAYLOAD + 2; c++) begin
            apply(1'b1, 1'b0);
            if (o_wr_en) wen_cnt++;
            tick();
        end
        chk("full_words_accepted", wen_cnt, 2 * PAYLOAD);
        apply(1'b1, 1'b0);
        chk("full_ready_low", o_ready, 0);
        tick();
        done = 0;
        for (int c = 0; c < 200; c++) begin
            apply(1'b0, 1'b1);
            if (o_eop) begin
                chk("full_ready_at_eop", o_ready, 0);
                tick();
                apply(1'b0, 1'b1);
                chk("full_ready_after_eop", o_ready, 1);
                done = 1;
            end
            tick();
            if (done) break;
        end
        chk("full_eop_seen", done, 1);

        // Alternating downstream ready: each address held for two cycles.
        do_reset();
        repeat (PAYLOAD) cycle(1'b1, 1'b0);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            apply(1'b0, 1'b0);
            if (o_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("toggle_start", found, 1);
        for (k = 0; k < 2 * P_BITS; k++) begin
            apply(1'b0, k[0]);
            chk("toggle_valid", o_valid, 1);
            chk("toggle_rd_addr", o_rd_addr, k / 2);
            chk("toggle_eop", o_eop, (k >= 2 * P_BITS - 2) ? 1 : 0);
            tick();
        end
        apply(1'b0, 1'b0);
        chk("toggle_valid_after", o_valid, 0);
        tick();

        // Asynchronous reset in the middle of a packet.
        do_reset();
        repeat (PAYLOAD) cycle(1'b1, 1'b1);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (o_valid && o_rd_addr == 6'd30) begin
                found = 1;
                break;
            end
            cycle(1'b0, 1'b1);
        end
        chk("midrst_reached_30", found, 1);
        i_reset_n = 1'b0;
        #1;
        m_reset();
        chk("midrst_valid",   o_valid,   0);
        chk("midrst_sop",     o_sop,     0);
        chk("midrst_wr_addr", o_wr_addr, FIRST);
        chk("midrst_ready",   o_ready,   1);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            apply(1'b0, 1'b1);
            chk("midrst_no_sop", o_sop, 0);
            tick();
        end

        // Random traffic against the model, with varying downstream pressure.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) thresh = $urandom_range(10, 100);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(1, 100) <= thresh));
        end
`ifdef PACK_CTRL_STATS_EN
        apply(1'b0, 1'b0);
        chk("stats_pack_cnt",  o_pack_cnt,  m_pack);
        chk("stats_stall_cnt", o_stall_cnt, m_stall);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
